// File: rtl/abc_pkt_tx_if.sv
// abc_pkt_tx_if: bundles the upstream write handshake and the abc output stream.
//   wr_valid/wr_ready/wr_data/wr_last : upstream word source (valid/ready, last marker)
//   abc_sop/abc_eop/abc_data          : abc stream, no valid qualifier
// Modports:
//   master : the side that produces words and observes the abc stream
//   slave  : the transmitter (abc_pkt_tx)
interface abc_pkt_tx_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        wr_last;
  logic        abc_sop;
  logic        abc_eop;
  logic [63:0] abc_data;

  modport master (
    output wr_valid, wr_data, wr_last,
    input  wr_ready, abc_sop, abc_eop, abc_data
  );

  modport slave (
    input  wr_valid, wr_data, wr_last,
    output wr_ready, abc_sop, abc_eop, abc_data
  );
endinterface

// File: rtl/abc_pkt_tx.sv
// abc_pkt_tx: store-and-forward packet transmitter for the abc stream.
// Whole packets are buffered in a FIFO and then sent contiguously, sop to eop.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus          : abc_pkt_tx_if.slave (write handshake in, abc stream out)
//   err_oversize : one-cycle pulse when a packet longer than DEPTH is dropped
//   pkt_cnt      : number of packets fully sent, wraps
// Build option:
//   ABC_TX_IPG_EN : when defined, enforce IPG idle cycles between eop and next sop.
//
// state | meaning
// IDLE  | waiting for a complete packet; pops and sends the first word
// SEND  | popping one word per cycle until the last word
// GAP   | inter-packet idle time (only with ABC_TX_IPG_EN)
// DROP  | oversize packet: FIFO flushed, discarding input up to wr_last
module abc_pkt_tx #(
  parameter int DEPTH = 16,
  parameter int IPG   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  abc_pkt_tx_if.slave      bus,
  output logic             err_oversize,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
`ifdef ABC_TX_IPG_EN
    , GAP = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [64:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      pkts_avail_q, pkts_avail_d;
  logic             last_fire_q;
  logic             rdy_q;
  logic             sop_q, sop_d, eop_q, eop_d;
  logic [63:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             full, wr_fire, wr_store, pkt_done;
  logic [64:0]      head;

`ifdef ABC_TX_IPG_EN
  localparam int GW = (IPG > 1) ? $clog2(IPG) : 1;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire  = bus.wr_valid && bus.wr_ready;
  assign wr_store = wr_fire && (state_q != DROP);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  // rdy_q holds wr_ready low through reset and for the release edge itself.
  assign bus.wr_ready = rdy_q && !full;
  assign bus.abc_sop  = sop_q;
  assign bus.abc_eop  = eop_q;
  assign bus.abc_data = data_q;
  assign err_oversize = err_q;
  assign pkt_cnt      = pkt_cnt_q;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    data_d    = '0;
    err_d     = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    pkt_done  = 1'b0;
`ifdef ABC_TX_IPG_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pkts_avail_q != '0) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          sop_d    = 1'b1;
          eop_d    = head[64];
          data_d   = head[63:0];
          if (head[64]) pkt_done = 1'b1;
          else          state_d  = SEND;
        end else if (full && !last_fire_q) begin
          // Full with no complete packet (and none about to be counted):
          // the packet in flight can never fit.
          state_d  = DROP;
          err_d    = 1'b1;
          rd_ptr_d = wr_ptr_q;
        end
      end
      SEND: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        eop_d    = head[64];
        data_d   = head[63:0];
        if (head[64]) pkt_done = 1'b1;
      end
      DROP: begin
        if (wr_fire && bus.wr_last) state_d = IDLE;
      end
`ifdef ABC_TX_IPG_EN
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (pkt_done) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
      state_d   = IDLE;
`ifdef ABC_TX_IPG_EN
      if (IPG > 0) begin
        state_d   = GAP;
        gap_cnt_d = GW'(IPG - 1);
      end
`endif
    end
  end

  // Completed packets become visible to the FSM one edge after their last
  // word is stored, which sets the write-to-sop latency.
  assign pkts_avail_d = pkts_avail_q + {{AW{1'b0}}, last_fire_q} - {{AW{1'b0}}, pkt_done};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkts_avail_q <= '0;
      last_fire_q  <= 1'b0;
      rdy_q        <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      pkt_cnt_q    <= '0;
`ifdef ABC_TX_IPG_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      pkts_avail_q <= pkts_avail_d;
      last_fire_q  <= wr_store && bus.wr_last;
      rdy_q        <= 1'b1;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      data_q       <= data_d;
      err_q        <= err_d;
      pkt_cnt_q    <= pkt_cnt_d;
`ifdef ABC_TX_IPG_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
      if (wr_store) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_store) mem_q[wr_ptr_q[AW-1:0]] <= {bus.wr_last, bus.wr_data};
  end

endmodule

// File: tb/tb_abc_pkt_tx.sv
module tb_abc_pkt_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_oversize;
  logic [15:0] pkt_cnt;

  abc_pkt_tx_if bus();

  abc_pkt_tx #(.DEPTH(16), .IPG(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .err_oversize (err_oversize),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

`ifdef ABC_TX_IPG_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 0;
`endif

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          exp_pkts = 0;
  int          err_cnt = 0;
  logic        in_pkt = 1'b0;
  logic [65:0] exp_q[$];
  int          sop_cyc[$];
  int          eop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every abc beat inside a packet pops one expected word.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt = 1'b0;
    end else begin
      if (err_oversize) err_cnt++;
      if (bus.abc_sop || in_pkt) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got sop=%b eop=%b data=%h want no output",
                   bus.abc_sop, bus.abc_eop, bus.abc_data);
        end else begin
          chk("abc_beat", {bus.abc_sop, bus.abc_eop, bus.abc_data}, exp_q.pop_front());
        end
        if (bus.abc_sop) sop_cyc.push_back(cyc);
        if (bus.abc_eop) eop_cyc.push_back(cyc);
        in_pkt = !bus.abc_eop;
      end else if (bus.abc_eop || bus.abc_data != 64'h0) begin
        checks++; errors++;
        $display("FAIL idle_output: got eop=%b data=%h want 0 0", bus.abc_eop, bus.abc_data);
      end
    end
  end

  task automatic put(input logic [63:0] d, input logic l);
    int t;
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_data = d; bus.wr_last = l;
    t = 0;
    while (!bus.wr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.wr_ready) begin
      checks++; errors++;
      $display("FAIL put_timeout: got wr_ready=0 want 1 within 100 cycles");
    end else begin
      @(posedge clk);
      #1;
      if (l) last_acc = cyc;
    end
    bus.wr_valid = 1'b0;
  endtask

  // Writes a packet; when expect_out is set, the expected beats are queued.
  task automatic put_pkt(input logic [63:0] base, input int n, input logic expect_out);
    for (int i = 0; i < n; i++) begin
      if (expect_out)
        exp_q.push_back({(i == 0), (i == n - 1), base + 64'(i)});
      put(base + 64'(i), (i == n - 1));
    end
    if (expect_out) exp_pkts++;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_pkt) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0 || in_pkt) begin
      checks++; errors++;
      $display("FAIL %s_drain: got %0d words pending want 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
    chk({name, "_pkt_cnt"}, 66'(pkt_cnt), 66'(exp_pkts[15:0]));
  endtask

  initial begin
    int s0, e0, eb;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 66'(bus.wr_ready), 66'd0);
    chk("rst_outputs", {bus.abc_sop, bus.abc_eop, bus.abc_data}, 66'd0);
    chk("rst_err", 66'(err_oversize), 66'd0);
    chk("rst_pkt_cnt", 66'(pkt_cnt), 66'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_wr_ready", 66'(bus.wr_ready), 66'd1);

    // 4-word packet, sop two edges after last word accepted
    s0 = sop_cyc.size();
    put_pkt(64'hA0, 4, 1'b1);
    wait_drain("pkt4");
    if (sop_cyc.size() > s0) chk("pkt4_latency", 66'(sop_cyc[s0] - last_acc), 66'd2);
    else begin checks++; errors++; $display("FAIL pkt4_latency: got no sop want sop"); end

    // Single-word packet
    put_pkt(64'hDEADBEEF_00000001, 1, 1'b1);
    wait_drain("single");

    // Two 3-word packets back-to-back
    s0 = sop_cyc.size(); e0 = eop_cyc.size();
    put_pkt(64'hB000_0000_0000_0010, 3, 1'b1);
    put_pkt(64'hC000_0000_0000_0020, 3, 1'b1);
    wait_drain("b2b");
    if (sop_cyc.size() >= s0 + 2 && eop_cyc.size() >= e0 + 1)
      chk("b2b_gap", 66'(sop_cyc[s0 + 1] - eop_cyc[e0] - 1), 66'(EXP_GAP));
    else begin checks++; errors++; $display("FAIL b2b_gap: got missing sop/eop want two packets"); end

    // Oversize packet dropped, following packet intact
    eb = err_cnt;
    put_pkt(64'hE000_0000_0000_0100, 20, 1'b0);
    put_pkt(64'h7000_0000_0000_0200, 2, 1'b1);
    wait_drain("oversize");
    chk("oversize_err_pulses", 66'(err_cnt - eb), 66'd1);

    // Upstream stall mid-packet
    s0 = sop_cyc.size();
    exp_q.push_back({1'b1, 1'b0, 64'h5500_0000_0000_0000});
    exp_q.push_back({1'b0, 1'b0, 64'h5500_0000_0000_0001});
    exp_q.push_back({1'b0, 1'b0, 64'h5500_0000_0000_0002});
    exp_q.push_back({1'b0, 1'b1, 64'h5500_0000_0000_0003});
    exp_pkts++;
    put(64'h5500_0000_0000_0000, 1'b0);
    put(64'h5500_0000_0000_0001, 1'b0);
    repeat (5) @(negedge clk);
    put(64'h5500_0000_0000_0002, 1'b0);
    put(64'h5500_0000_0000_0003, 1'b1);
    wait_drain("stall");
    if (sop_cyc.size() > s0) chk("stall_latency", 66'(sop_cyc[s0] - last_acc), 66'd2);
    else begin checks++; errors++; $display("FAIL stall_latency: got no sop want sop"); end

    // Reset during word 2 of a 6-word transmission
    s0 = sop_cyc.size();
    put_pkt(64'h6600_0000_0000_0000, 6, 1'b1);
    for (int t = 0; t < 50 && sop_cyc.size() == s0; t++) begin
      @(negedge clk); #1;
    end
    if (sop_cyc.size() == s0) begin
      checks++; errors++; $display("FAIL mid_rst_sop: got no sop want sop");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_pkts = 0;
    chk("mid_rst_outputs", {bus.abc_sop, bus.abc_eop, bus.abc_data}, 66'd0);
    chk("mid_rst_pkt_cnt", 66'(pkt_cnt), 66'd0);
    chk("mid_rst_wr_ready", 66'(bus.wr_ready), 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    put_pkt(64'h9900_0000_0000_0000, 3, 1'b1);
    wait_drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
